// File: rtl/approx_add_pkg.sv
// Shared constants and arithmetic helpers for the approximate adder pipeline.
// Helpers work on MAX_W-wide zero-extended operands so any W < MAX_W can use them.
package approx_add_pkg;

  localparam int   MAX_W       = 64;
  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Lower k bits are OR-ed; the top of that field still produces a carry into the exact upper part.
  function automatic logic [MAX_W:0] approx_sum(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input int unsigned      k);
    logic [MAX_W:0] lo;
    logic [MAX_W:0] hi;
    logic           c;
    lo = '0;
    c  = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < int'(k)) lo[i] = a[i] | b[i];
      if (k > 0 && i == int'(k) - 1) c = a[i] & b[i];
    end
    hi = (({1'b0, a} >> k) + ({1'b0, b} >> k) + {{MAX_W{1'b0}}, c}) << k;
    return hi | lo;
  endfunction

  function automatic logic [MAX_W:0] err_mag(input logic [MAX_W:0] x,
                                             input logic [MAX_W:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/approx_add_stat.sv
// Error statistics: running maximum error and saturating count of erroneous beats.
module approx_add_stat #(
  parameter int W     = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             fire,
  input  logic [W:0]       err,
  output logic [W:0]       max_err,
  output logic [CNT_W-1:0] err_cnt
);

  // Clear has priority over a beat delivered in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_err <= '0;
      err_cnt <= '0;
    end else if (clr) begin
      max_err <= '0;
      err_cnt <= '0;
    end else if (fire) begin
      if (err > max_err) max_err <= err;
      if (err != '0 && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/approx_add_pipe.sv
// Exact/approximate adder with a stall-together valid/ready pipeline and error statistics.
// Both results ride the pipe; the error is formed at the output stage.
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int W      = 12,
  parameter int K      = 5,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       sum,
  input  logic             stat_clr,
  output logic [W:0]       max_err,
  output logic [CNT_W-1:0] err_cnt
);

  generate
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
      $error("approx_add_pipe: STAGES must be 1, 2 or 3");
    end
    if (K < 0 || K >= W) begin : g_bad_k
      $error("approx_add_pipe: K must satisfy 0 <= K < W");
    end
    if (W < 4 || W >= MAX_W) begin : g_bad_w
      $error("approx_add_pipe: W out of supported range");
    end
  endgenerate

  logic [MAX_W-1:0]           a_x, b_x;
  logic [MAX_W:0]             appr_x, err_x;
  logic [W:0]                 exact_in, sel_in, err_out;
  logic [STAGES-1:0]          vld_q;
  logic [STAGES:0]            vld_pipe;
  logic [STAGES-1:0][W:0]     exact_q, sel_q;
  logic [STAGES:0][W:0]       exact_pipe, sel_pipe;
  logic                       adv, fire;
  logic                       unused_hi;

  assign a_x      = MAX_W'(a);
  assign b_x      = MAX_W'(b);
  assign appr_x   = approx_sum(a_x, b_x, K);
  assign exact_in = {1'b0, a} + {1'b0, b};
  // Mode is resolved at capture, so a beat's result never depends on later mode changes.
  assign sel_in   = (mode == MODE_APPROX) ? appr_x[W:0] : exact_in;

  // Slot 0 of each *_pipe view is the incoming beat; slot s+1 is register s.
  assign vld_pipe   = {vld_q, in_valid};
  assign exact_pipe = {exact_q, exact_in};
  assign sel_pipe   = {sel_q, sel_in};

  assign adv      = out_ready | ~vld_q[STAGES-1];
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      exact_q <= '0;
      sel_q   <= '0;
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s]   <= vld_pipe[s];
        exact_q[s] <= exact_pipe[s];
        sel_q[s]   <= sel_pipe[s];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = sel_q[STAGES-1];
  assign fire      = out_valid & out_ready;

  assign err_x     = err_mag((MAX_W+1)'(exact_q[STAGES-1]), (MAX_W+1)'(sel_q[STAGES-1]));
  assign err_out   = err_x[W:0];
  assign unused_hi = ^{appr_x[MAX_W:W+1], err_x[MAX_W:W+1]};

  approx_add_stat #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_stat (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (stat_clr),
    .fire    (fire),
    .err     (err_out),
    .max_err (max_err),
    .err_cnt (err_cnt)
  );

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed bench for approx_add_pipe (W=12, K=5, STAGES=2, CNT_W=4 for saturation).
module tb_approx_add_pipe;

  localparam int W  = 12;
  localparam int K  = 5;
  localparam int ST = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, out_ready, mode, stat_clr;
  logic [W-1:0]  a, b;
  logic          in_ready, out_valid;
  logic [W:0]    sum, max_err;
  logic [CW-1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  approx_add_pipe #(.W(W), .K(K), .STAGES(ST), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .stat_clr(stat_clr), .max_err(max_err), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for K=5: OR the low five bits, carry = bit 4 of both, add the upper seven.
  function automatic logic [W:0] model_appr(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [4:0] lo;
    logic [7:0] hi;
    lo = x[4:0] | y[4:0];
    hi = {1'b0, x[11:5]} + {1'b0, y[11:5]} + {7'd0, x[4] & y[4]};
    return {hi, lo};
  endfunction

  logic [W-1:0] va [8];
  logic [W-1:0] vb [8];
  logic         vm [8];
  logic [W:0]   exp_sum [8];
  logic [W:0]   got [$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] held, ex, ap, e, mx;
    int idx, cnt;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
    a = '0; b = '0; stat_clr = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_max_err", max_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single approximate beat with latency check.
    a = 12'h01F; b = 12'h001; mode = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat1_out_valid", out_valid, 0);
    step();
    chk("lat2_out_valid", out_valid, 1);
    chk("approx_1f_1", sum, 13'h01F);
    step();
    chk("deliv_out_valid", out_valid, 0);
    chk("stat1_max_err", max_err, 1);
    chk("stat1_err_cnt", err_cnt, 1);

    // Same operands in approximate then exact mode, back to back.
    a = 12'hFFF; b = 12'hFFF; mode = 1'b1; in_valid = 1'b1;
    step();
    mode = 1'b0;
    step();
    in_valid = 1'b0; mode = 1'b1;
    chk("approx_fff", sum, 13'h1FFF);
    step();
    chk("exact_fff", sum, 13'h1FFE);
    chk("cnt_after_approx", err_cnt, 2);
    step();
    chk("cnt_after_exact", err_cnt, 2);
    chk("max_after_fff", max_err, 1);
    chk("idle_out_valid", out_valid, 0);

    // Clear, then 8 back-to-back beats with out_ready low in cycles 3..5.
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_max_err", max_err, 0);

    va[0] = 12'h01F; vb[0] = 12'h001; vm[0] = 1'b1;
    va[1] = 12'h010; vb[1] = 12'h010; vm[1] = 1'b1;
    va[2] = 12'h123; vb[2] = 12'h456; vm[2] = 1'b0;
    va[3] = 12'h0FF; vb[3] = 12'h001; vm[3] = 1'b1;
    va[4] = 12'hABC; vb[4] = 12'h321; vm[4] = 1'b1;
    va[5] = 12'h800; vb[5] = 12'h800; vm[5] = 1'b0;
    va[6] = 12'h7FF; vb[6] = 12'h001; vm[6] = 1'b1;
    va[7] = 12'h000; vb[7] = 12'h000; vm[7] = 1'b1;
    mx = '0; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      ex = {1'b0, va[i]} + {1'b0, vb[i]};
      ap = model_appr(va[i], vb[i]);
      exp_sum[i] = vm[i] ? ap : ex;
      e = (ex >= exp_sum[i]) ? ex - exp_sum[i] : exp_sum[i] - ex;
      if (e > mx) mx = e;
      if (e != 0) cnt++;
    end

    idx = 0; held = '0;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (idx < 8);
      a    = (idx < 8) ? va[idx] : '0;
      b    = (idx < 8) ? vb[idx] : '0;
      mode = (idx < 8) ? vm[idx] : 1'b0;
      #4;
      if (c >= 3 && c <= 5) chk("stall_in_ready", in_ready, 0);
      if (c == 3) held = sum;
      if (c >= 4 && c <= 6) chk("stall_sum_held", sum, held);
      if (out_valid && out_ready) got.push_back(sum);
      if (in_valid && in_ready) idx++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", got.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("bp_order", (i < got.size()) ? got[i] : 13'h1FFF ^ exp_sum[i], exp_sum[i]);
    chk("bp_max_err", max_err, mx);
    chk("bp_err_cnt", err_cnt, cnt);

    // Clear coincident with delivery of an erroneous beat.
    a = 12'h01F; b = 12'h001; mode = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("clrco_out_valid", out_valid, 1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clrco_max_err", max_err, 0);
    chk("clrco_err_cnt", err_cnt, 0);
    step();
    chk("clrco_err_cnt_after", err_cnt, 0);

    // Saturation: 20 erroneous beats into a 4-bit counter.
    a = 12'h01F; b = 12'h001; mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 11) chk("sat_mid_cnt", err_cnt, 10);
    end
    in_valid = 1'b0;
    step(); step(); step();
    chk("sat_err_cnt", err_cnt, 15);
    chk("sat_max_err", max_err, 1);

    // Reset mid-stream with two beats in flight.
    a = 12'h123; b = 12'h001; mode = 1'b0; in_valid = 1'b1;
    step();
    a = 12'h200;
    step();
    in_valid = 1'b0;
    chk("pre_rst_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_err_cnt", err_cnt, 0);
    chk("async_rst_max_err", max_err, 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_stale", out_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/approx_add_pipe.md
APPROX_ADD_PIPE -- requirements
Module: approx_add_pipe

Interface
REQ-001 Parameter W, default 12, operand width in bits (W >= 4).
REQ-002 Parameter K, default 5, approximated LSB count (0 <= K < W; K=0 means always exact).
REQ-003 Parameter STAGES, default 2, pipeline register depth, one of {1,2,3}.
REQ-004 Parameter CNT_W, default 16, error-counter width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  operand beat valid.
REQ-008 in_ready  out  1  block can accept a beat.
REQ-009 a, b  in  W each  unsigned operands.
REQ-010 mode  in  1  per-beat select; 0 exact, 1 approximate.
REQ-011 out_valid  out  1  result beat valid.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 sum  out  W+1  result.
REQ-014 stat_clr  in  1  synchronous clear of statistics.
REQ-015 max_err  out  W+1  largest |exact-approx| seen since last clear.
REQ-016 err_cnt  out  CNT_W  count of delivered beats with nonzero error, saturating.

Function
REQ-017 Exact result SHALL be a+b, W+1 bits.
REQ-018 Approximate result SHALL be: sum[K-1:0] = a[K-1:0] | b[K-1:0]; carry into upper part = a[K-1] & b[K-1] (0 when K=0); sum[W:K] = a[W-1:K] + b[W-1:K] + carry.
REQ-019 mode SHALL be captured with its operands and travel with the beat; changing mode never affects beats in flight.
REQ-020 Each beat SHALL carry both exact and selected results; error = |exact - selected| (always 0 for mode=0).
REQ-021 Pipeline SHALL be STAGES register stages with one global advance signal adv = out_ready | ~out_valid.
REQ-022 in_ready SHALL equal adv, combinationally; a beat is accepted when in_valid & in_ready.
REQ-023 On adv, every stage SHALL shift one position; stage-0 valid loads in_valid; latency from acceptance to out_valid SHALL be exactly STAGES cycles with out_ready held high.
REQ-024 When adv=0 all stage registers, including sum and out_valid, SHALL hold; sum stable while out_valid & ~out_ready.
REQ-025 Throughput SHALL be one beat per cycle with out_ready high; bubbles (in_valid=0) propagate as invalid slots.
REQ-026 Statistics SHALL update only on a delivered beat (out_valid & out_ready): max_err <= max(max_err, error); err_cnt increments if error != 0.
REQ-027 err_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-028 stat_clr SHALL zero max_err and err_cnt next cycle; when coincident with a delivered beat, clear wins and that beat is not counted.
REQ-029 stat_clr SHALL not affect the data path or handshake.

Reset
REQ-030 On rst_n low, all stage valids, out_valid, sum, max_err and err_cnt SHALL go to 0 immediately, independent of clk.
REQ-031 Beats in flight at reset assertion SHALL be discarded; no partial beat delivered after deassertion.
REQ-032 in_ready SHALL be 1 during and after reset (out_valid=0).

Structure
REQ-033 A shared package SHALL hold the approximate-sum function (W, K generic), the error-magnitude function, and the mode encoding constants MODE_EXACT=0, MODE_APPROX=1.
REQ-034 One sub-module, approx_add_stat, SHALL contain the max-error register and saturating counter; the datapath and pipeline stay in approx_add_pipe.
REQ-035 STAGES outside {1,2,3} or K >= W SHALL fail elaboration.

Verification (W=12, K=5, STAGES=2)
REQ-036 mode=1, a=0x01F, b=0x001 -> sum=0x01F after 2 cycles; max_err=1, err_cnt=1.
REQ-037 mode=1, a=0xFFF, b=0xFFF -> sum=0x1FFF; mode=0 same operands -> sum=0x1FFE, err_cnt unchanged.
REQ-038 Back-to-back 8 beats, out_ready low cycles 3-5 -> in_ready low those cycles, sum held, all 8 results delivered in order, none lost or duplicated.
REQ-039 stat_clr asserted in same cycle as delivered erroneous beat -> max_err=0, err_cnt=0 next cycle.
REQ-040 CNT_W=4, 20 erroneous beats -> err_cnt stops at 15.
REQ-041 rst_n pulsed low mid-stream with 2 beats in flight -> out_valid=0 immediately, no stale beat after release, in_ready=1.
